// File: rtl/forward_scoreboard.sv
// Forwarding and load-use hazard unit beside the ID/EX register: a shadow shift register of
// destination state for EX and DEPTH later stages drives the bypass selects and the ID stall.
module forward_scoreboard #(
    parameter int DEPTH      = 2,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             stall_ext,
    output logic [SEL_W-1:0] fwd_rs1,
    output logic [SEL_W-1:0] fwd_rs2,
    output logic             stall_id,
    output logic [15:0]      stall_count,
    output logic             hazard_err
);

    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Slot 0 is EX, slots 1..DEPTH are the later stages.
    logic [DEPTH:0] valid_q;
    logic [DEPTH:0] wr_q;
    logic [DEPTH:0] ld_q;
    logic [4:0]     rd_q [0:DEPTH];
    logic [4:0]     ex_rs1_q;
    logic [4:0]     ex_rs2_q;
    logic           ex_use1_q;
    logic           ex_use2_q;

    logic           ex_use1;
    logic           ex_use2;
    logic           id_use1;
    logic           id_use2;
    logic [4:0]     id_src1;
    logic [DEPTH:0] live;
    logic [DEPTH:0] m_ex1;
    logic [DEPTH:0] m_ex2;
    logic [DEPTH:0] m_id1;
    logic [DEPTH:0] m_id2;
    logic           hit1;
    logic           hit2;
    logic           haz1;
    logic           haz2;
    logic           take;

    // Only fields the opcode actually reads may forward or stall; ECALL reads a7 implicitly.
    always_comb begin
        id_use1 = 1'b0;
        id_use2 = 1'b0;
        id_src1 = id_rs1;
        case (id_opcode)
            OP_ARITH, OP_STORE, OP_BRANCH: begin
                id_use1 = 1'b1;
                id_use2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: id_use1 = 1'b1;
            OP_SYSTEM: begin
                id_use1 = 1'b1;
                id_src1 = 5'd17;
            end
            default: ;
        endcase
    end

    assign ex_use1 = valid_q[0] & ex_use1_q;
    assign ex_use2 = valid_q[0] & ex_use2_q;

    always_comb begin
        live  = '0;
        m_ex1 = '0;
        m_ex2 = '0;
        m_id1 = '0;
        m_id2 = '0;
        for (int p = 0; p <= DEPTH; p++) begin
            live[p]  = valid_q[p] & wr_q[p] & (rd_q[p] != 5'd0);
            m_ex1[p] = live[p] & (rd_q[p] == ex_rs1_q);
            m_ex2[p] = live[p] & (rd_q[p] == ex_rs2_q);
            m_id1[p] = live[p] & (rd_q[p] == id_src1);
            m_id2[p] = live[p] & (rd_q[p] == id_rs2);
        end
    end

    // Scanning oldest to youngest lets the nearest producer overwrite older ones.
    always_comb begin
        fwd_rs1 = '0;
        fwd_rs2 = '0;
        haz1    = 1'b0;
        haz2    = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (ex_use1 && m_ex1[k]) begin
                fwd_rs1 = SEL_W'(k);
                haz1    = ld_q[k] && (k < LOAD_READY);
            end
            if (ex_use2 && m_ex2[k]) begin
                fwd_rs2 = SEL_W'(k);
                haz2    = ld_q[k] && (k < LOAD_READY);
            end
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int p = DEPTH; p >= 0; p--) begin
            if (id_use1 && m_id1[p]) hit1 = ld_q[p] && ((p + 1) < LOAD_READY);
            if (id_use2 && m_id2[p]) hit2 = ld_q[p] && ((p + 1) < LOAD_READY);
        end
    end

    // Handshake: id_valid qualifies the id_* fields; stall_id asks upstream to hold them; the
    // instruction enters EX on an edge with id_valid & !stall_id & !flush & !stall_ext.
    assign stall_id = id_valid & ~flush & (hit1 | hit2);
    assign take     = id_valid & ~flush & ~stall_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            stall_count <= 16'd0;
            hazard_err  <= 1'b0;
        end else if (!stall_ext) begin
            for (int k = DEPTH; k >= 1; k--) begin
                valid_q[k] <= valid_q[k-1];
                wr_q[k]    <= wr_q[k-1];
                ld_q[k]    <= ld_q[k-1];
                rd_q[k]    <= rd_q[k-1];
            end
            valid_q[0] <= take;
            wr_q[0]    <= id_reg_write;
            ld_q[0]    <= id_is_load;
            rd_q[0]    <= id_rd;
            ex_rs1_q   <= id_src1;
            ex_rs2_q   <= id_rs2;
            ex_use1_q  <= id_use1;
            ex_use2_q  <= id_use2;
            if (stall_id && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
            if (haz1 || haz2) hazard_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed instruction sequences on three parameterisations,
// hand-computed expectations queued per cycle and checked by a separate monitor.
module tb_forward_scoreboard;

    localparam logic [6:0] ARITH  = 7'b0110011;
    localparam logic [6:0] IMM    = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] LUI    = 7'b0110111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, id_valid, id_reg_write, id_is_load, flush, stall_ext;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic [1:0]  a_f1, a_f2, b_f1, b_f2;
    logic [4:0]  c_f1, c_f2;
    logic        a_st, b_st, c_st, a_err, b_err, c_err;
    logic [15:0] a_cnt, b_cnt, c_cnt;

    forward_scoreboard dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .stall_ext(stall_ext),
        .fwd_rs1(a_f1), .fwd_rs2(a_f2), .stall_id(a_st), .stall_count(a_cnt), .hazard_err(a_err)
    );

    forward_scoreboard #(.DEPTH(3), .LOAD_READY(3)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .stall_ext(stall_ext),
        .fwd_rs1(b_f1), .fwd_rs2(b_f2), .stall_id(b_st), .stall_count(b_cnt), .hazard_err(b_err)
    );

    forward_scoreboard #(.DEPTH(31), .LOAD_READY(31)) dut_c (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .stall_ext(stall_ext),
        .fwd_rs1(c_f1), .fwd_rs2(c_f2), .stall_id(c_st), .stall_count(c_cnt), .hazard_err(c_err)
    );

    // Expected record: {fwd_rs1[4:0], fwd_rs2[4:0], stall_id, stall_count[15:0], hazard_err}
    logic [27:0] exp_q[$];
    int          dut_q[$];
    string       name_q[$];
    logic        chk;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [27:0] mon_act, mon_exp;
    int          mon_dut;
    string       mon_name;

    always @(negedge clk) begin
        if (chk) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL monitor: check cycle with no expected entry");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_dut  = dut_q.pop_front();
                mon_name = name_q.pop_front();
                case (mon_dut)
                    0:       mon_act = {3'd0, a_f1, 3'd0, a_f2, a_st, a_cnt, a_err};
                    1:       mon_act = {3'd0, b_f1, 3'd0, b_f2, b_st, b_cnt, b_err};
                    default: mon_act = {c_f1, c_f2, c_st, c_cnt, c_err};
                endcase
                n_tests++;
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL %s (dut%0d): got fwd_rs1=%0d fwd_rs2=%0d stall_id=%0b stall_count=%0d hazard_err=%0b, expected fwd_rs1=%0d fwd_rs2=%0d stall_id=%0b stall_count=%0d hazard_err=%0b",
                             mon_name, mon_dut, mon_act[27:23], mon_act[22:18], mon_act[17],
                             mon_act[16:1], mon_act[0], mon_exp[27:23], mon_exp[22:18],
                             mon_exp[17], mon_exp[16:1], mon_exp[0]);
                end
            end
        end
    end

    task automatic ins(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic wr, input logic ld);
        id_valid     = 1'b1;
        id_opcode    = op;
        id_rs1       = r1;
        id_rs2       = r2;
        id_rd        = rd;
        id_reg_write = wr;
        id_is_load   = ld;
    endtask

    task automatic nop();
        id_valid     = 1'b0;
        id_opcode    = 7'd0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_rd        = 5'd0;
        id_reg_write = 1'b0;
        id_is_load   = 1'b0;
    endtask

    task automatic chkv(input int d, input string nm, input int f1, input int f2,
                        input logic st, input int cnt, input logic err);
        exp_q.push_back({5'(f1), 5'(f2), st, 16'(cnt), err});
        dut_q.push_back(d);
        name_q.push_back(nm);
        chk = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic do_reset(input int d);
        reset     = 1'b1;
        flush     = 1'b0;
        stall_ext = 1'b0;
        nop();
        tick();
        reset = 1'b0;
        chkv(d, "reset_state", 0, 0, 1'b0, 0, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; stall_ext = 1'b0; chk = 1'b0;
        nop();

        // add x5,x1,x2 ; sub x6,x5,x5
        do_reset(0);
        ins(ARITH, 1, 2, 5, 1, 0); chkv(0, "alu_add_id", 0, 0, 0, 0, 0); tick();
        ins(ARITH, 5, 5, 6, 1, 0); chkv(0, "alu_sub_id", 0, 0, 0, 0, 0); tick();
        nop();                     chkv(0, "alu_sub_fwd", 1, 1, 0, 0, 0); tick();
        chkv(0, "alu_bubble", 0, 0, 0, 0, 0); tick();

        // lw x7,0(x1) ; add x8,x7,x0
        do_reset(0);
        ins(LOAD, 1, 0, 7, 1, 1);  chkv(0, "lu_lw", 0, 0, 0, 0, 0); tick();
        ins(ARITH, 7, 0, 8, 1, 0); chkv(0, "lu_stall", 0, 0, 1, 0, 0); tick();
        chkv(0, "lu_release", 0, 0, 0, 1, 0); tick();
        nop();                     chkv(0, "lu_fwd2", 2, 0, 0, 1, 0); tick();
        chkv(0, "lu_after", 0, 0, 0, 1, 0); tick();

        // lw x7 ; addi x7,x0,1 ; add x9,x7,x7
        do_reset(0);
        ins(LOAD, 1, 0, 7, 1, 1);  chkv(0, "mask_lw", 0, 0, 0, 0, 0); tick();
        ins(IMM, 0, 1, 7, 1, 0);   chkv(0, "mask_addi", 0, 0, 0, 0, 0); tick();
        ins(ARITH, 7, 7, 9, 1, 0); chkv(0, "mask_no_stall", 0, 0, 0, 0, 0); tick();
        nop();                     chkv(0, "mask_fwd", 1, 1, 0, 0, 0); tick();

        // unused rs2 of addi, ecall reading x17, lui reading nothing
        do_reset(0);
        ins(IMM, 0, 0, 5, 1, 0);     chkv(0, "unused_prod", 0, 0, 0, 0, 0); tick();
        ins(IMM, 4, 5, 3, 1, 0);     chkv(0, "unused_id", 0, 0, 0, 0, 0); tick();
        nop();                       chkv(0, "unused_rs2", 0, 0, 0, 0, 0); tick();
        ins(IMM, 0, 10, 17, 1, 0);   chkv(0, "ecall_prod", 0, 0, 0, 0, 0); tick();
        ins(SYSTEM, 0, 0, 0, 0, 0);  chkv(0, "ecall_id", 0, 0, 0, 0, 0); tick();
        ins(LUI, 17, 17, 10, 1, 0);  chkv(0, "ecall_fwd", 1, 0, 0, 0, 0); tick();
        nop();                       chkv(0, "lui_nosrc", 0, 0, 0, 0, 0); tick();

        // x0 never forwarded, unused rs2 never stalls, store rs2 does
        do_reset(0);
        ins(LOAD, 1, 0, 0, 1, 1);   chkv(0, "x0_lw", 0, 0, 0, 0, 0); tick();
        ins(ARITH, 0, 0, 2, 1, 0);  chkv(0, "x0_no_stall", 0, 0, 0, 0, 0); tick();
        ins(LOAD, 1, 0, 5, 1, 1);   chkv(0, "x0_no_fwd", 0, 0, 0, 0, 0); tick();
        ins(IMM, 4, 5, 3, 1, 0);    chkv(0, "unused_no_stall", 0, 0, 0, 0, 0); tick();
        ins(LOAD, 1, 0, 6, 1, 1);   chkv(0, "st_lw", 0, 0, 0, 0, 0); tick();
        ins(STORE, 0, 6, 0, 0, 0);  chkv(0, "st_rs2_stall", 0, 0, 1, 0, 0); tick();
        nop();                      chkv(0, "st_release", 0, 0, 0, 1, 0); tick();

        // stall_ext freezes slots and counter during a load-use hazard
        do_reset(0);
        ins(LOAD, 1, 0, 7, 1, 1);  chkv(0, "ext_lw", 0, 0, 0, 0, 0); tick();
        ins(ARITH, 7, 0, 8, 1, 0);
        stall_ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chkv(0, "ext_frozen", 0, 0, 1, 0, 0); tick();
        end
        stall_ext = 1'b0;
        chkv(0, "ext_resume", 0, 0, 1, 0, 0); tick();
        chkv(0, "ext_release", 0, 0, 0, 1, 0); tick();
        nop();                     chkv(0, "ext_fwd2", 2, 0, 0, 1, 0); tick();

        // reset asserted (together with stall_ext) while a stall is raised
        do_reset(0);
        ins(LOAD, 1, 0, 7, 1, 1);   chkv(0, "rst_lw", 0, 0, 0, 0, 0); tick();
        ins(LOAD, 7, 0, 9, 1, 1);   chkv(0, "rst_stall1", 0, 0, 1, 0, 0); tick();
        chkv(0, "rst_release", 0, 0, 0, 1, 0); tick();
        ins(ARITH, 9, 0, 10, 1, 0);
        reset = 1'b1; stall_ext = 1'b1;
        chkv(0, "rst_stall2", 2, 0, 1, 1, 0); tick();
        reset = 1'b0; stall_ext = 1'b0;
        chkv(0, "rst_cleared", 0, 0, 0, 0, 0); tick();
        nop();

        // flush on a raw stall condition inserts a bubble and does not count
        do_reset(0);
        ins(LOAD, 1, 0, 7, 1, 1);  chkv(0, "fl_lw", 0, 0, 0, 0, 0); tick();
        ins(ARITH, 7, 0, 8, 1, 0);
        flush = 1'b1;              chkv(0, "fl_no_stall", 0, 0, 0, 0, 0); tick();
        flush = 1'b0;
        nop();                     chkv(0, "fl_bubble", 0, 0, 0, 0, 0); tick();
        chkv(0, "fl_no_err", 0, 0, 0, 0, 0); tick();

        // DEPTH=3, LOAD_READY=3: two stall cycles, then select 3
        do_reset(1);
        ins(LOAD, 1, 0, 7, 1, 1);  chkv(1, "d3_lw", 0, 0, 0, 0, 0); tick();
        ins(ARITH, 7, 0, 8, 1, 0); chkv(1, "d3_stall1", 0, 0, 1, 0, 0); tick();
        chkv(1, "d3_stall2", 0, 0, 1, 1, 0); tick();
        chkv(1, "d3_release", 0, 0, 0, 2, 0); tick();
        nop();                     chkv(1, "d3_fwd3", 3, 0, 0, 2, 0); tick();

        // DEPTH=31, LOAD_READY=31: 30 stall cycles per 31, run past 65535 stalls
        do_reset(2);
        for (int it = 0; it < 2186; it++) begin
            ins(LOAD, 0, 0, 7, 1, 1);
            if (it == 100)  chkv(2, "sat_count_3000", 0, 0, 0, 3000, 0);
            if (it == 2184) chkv(2, "sat_count_65520", 0, 0, 0, 65520, 0);
            if (it == 2185) chkv(2, "sat_hold_ffff", 0, 0, 0, 65535, 0);
            tick();
            ins(ARITH, 7, 0, 8, 1, 0);
            for (int j = 1; j <= 30; j++) begin
                if (it == 100 && j == 1)   chkv(2, "sat_stall", 0, 0, 1, 3000, 0);
                if (it == 2184 && j == 16) chkv(2, "sat_reach_ffff", 0, 0, 1, 65535, 0);
                if (it == 2184 && j == 17) chkv(2, "sat_saturated", 0, 0, 1, 65535, 0);
                tick();
            end
        end
        nop();
        tick();

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover: %0d expected entries never checked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
